iobuff: RTL and testbench
=========================

Name: iobuff

Overview:
- Per-pin I/O buffer controller for one or more bus pins.
- Each pin sits behind a 74LVC1T45 level-shifting transceiver and a 74LVC1G07 open-drain buffer.
- Maps a logical request (enable, open-drain, direction, data) onto the two buffer control pins and the FPGA tristate data pin.
- Returns the synchronized pin level to protocol logic.
- Instantiated once per I/O pin group between the protocol engines and the top-level tristate primitives.

Parameters:
- WIDTH, 1, number of independent pin channels; every per-pin port is WIDTH bits wide.
- SYNC_STAGES, 2, flip-flop stages on the pin readback path (minimum 2).
- TURN_CYCLES, 1, all-Hi-Z break-before-make cycles inserted on any drive-mode change (minimum 1).

Ports:
- clk  input  1  system clock, all state rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- oe  input  WIDTH  1 = pin enabled; 0 = pin fully Hi-Z.
- od  input  WIDTH  1 = open-drain output, 0 = push-pull output.
- dir  input  WIDTH  0 = output, 1 = input.
- din  input  WIDTH  value to drive when output.
- dout  output  WIDTH  synchronized pin level.
- bufdir  output  WIDTH  74LVC1T45 DIR; LOW = toward FPGA / Hi-Z on the bus side.
- bufod  output  WIDTH  74LVC1G07 input; HIGH = released (Hi-Z).
- bufdat_tristate_oe  output  WIDTH  FPGA tristate data pin enable.
- bufdat_tristate_dout  output  WIDTH  FPGA tristate data pin output value.
- bufdat_tristate_din  input  WIDTH  FPGA tristate data pin input value (asynchronous).

Behaviour:
- Per-channel mode decode from (oe, od, dir): HIZ if oe=0; INPUT if oe=1 and dir=1; PP if oe=1, dir=0, od=0; OD if oe=1, dir=0, od=1.
- Per-channel FSM states: HIZ, INPUT, PP, OD, TURN.
- All control outputs are registered: one clk of latency from input change to pin change.
- Output values per state:
  - HIZ / TURN / INPUT: bufdir=0, bufod=1, bufdat_tristate_oe=0, bufdat_tristate_dout=0.
  - PP: bufdir=1, bufod=1, bufdat_tristate_oe=1, bufdat_tristate_dout=din.
  - OD: bufdir=0, bufod=din (0 pulls low, 1 releases), bufdat_tristate_oe=0, bufdat_tristate_dout=0.
- Transitions:
  - Decoded mode equals current state: stay. In PP and OD, din changes take effect next cycle without passing through TURN.
  - Decoded mode is a drive state (PP or OD) that differs from the current state, and the current state is PP or OD: enter TURN for TURN_CYCLES cycles, then the currently decoded mode.
  - Any other change: go directly to the decoded mode.
  - Mode changes again during TURN: TURN completes, then the latest decoded mode is taken.
  - Any change to oe=0: HIZ next cycle, no turnaround.
- bufdir and bufdat_tristate_oe are never both 1 unless in PP. bufod=0 only in OD.
- dout: bufdat_tristate_din through SYNC_STAGES flops in all states, so open-drain readback works. Latency is SYNC_STAGES cycles.
- Reset (asynchronous assert, synchronous release):
  - State = HIZ; bufdir=0, bufod=1, bufdat_tristate_oe=0, bufdat_tristate_dout=0, sync flops and dout=0.
  - Reset mid-drive releases the pin immediately.
- Channels are fully independent; X-free outputs whenever rst_n is applied.

Optional Feature:
- Macro IOBUFF_CONTENTION_DETECT_EN.
- When defined:
  - Adds output contention (WIDTH bits, reset 0).
  - Per channel, in PP or OD, a bit is set when synchronized dout differs from din after din has been stable for SYNC_STAGES+1 cycles.
  - In OD, a mismatch counts only when din=0 (pin failed to pull low).
  - The bit is sticky until oe=0.
- When undefined: the port and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package iobuff_pkg holds:
  - mode enum (HIZ, INPUT, PP, OD, TURN);
  - constants BUFDIR_HIZ=0, BUFOD_HIZ=1;
  - default SYNC_STAGES and TURN_CYCLES.
- One sub-module, iobuff_chan, implements the FSM, registered outputs and synchronizer for a single pin. iobuff is a generate loop over WIDTH.

Test Plan:
- Reset with rst_n=0, then oe=0, od=0, dir=0, din=0 -> bufdir=0, bufod=1, bufdat_tristate_oe=0, bufdat_tristate_dout=0, dout=0.
- oe=1, od=0, dir=0, din=0 for 20 cycles -> after 1 clk bufdir=1, bufod=1, bufdat_tristate_oe=1, bufdat_tristate_dout=0. Then din=1 -> bufdat_tristate_dout=1 next clk, no TURN.
- From PP with din=1, set od=1 -> TURN_CYCLES cycles all Hi-Z (bufdir=0, bufod=1, bufdat_tristate_oe=0), then OD with bufod=1. Then din=0 -> bufod=0 next clk.
- oe=1, dir=1 with bufdat_tristate_din toggled 0→1 -> all control outputs Hi-Z; dout=1 exactly SYNC_STAGES clks after the toggle.
- Assert rst_n=0 asynchronously while in PP driving 1 -> bufdat_tristate_oe=0 and bufdir=0 immediately, without waiting for clk.
- With IOBUFF_CONTENTION_DETECT_EN: PP driving din=1 while bufdat_tristate_din held at 0 -> contention=1 after SYNC_STAGES+1 cycles; oe=0 clears it.

Source files
------------

// File: rtl/iobuff_pkg.sv
// iobuff_pkg -- shared definitions for the iobuff pin controller.
//   mode_e          : per-channel mode / FSM state encoding
//   BUFDIR_HIZ      : 74LVC1T45 DIR level that isolates the bus side
//   BUFOD_HIZ       : 74LVC1G07 input level that releases the pin
//   *_DEF           : default synchronizer depth and turnaround length
//   decode_mode()   : maps the (oe, od, dir) request onto a mode
//   is_drive()      : true for modes that actively drive the pin
package iobuff_pkg;

  typedef enum logic [2:0] {
    HIZ   = 3'd0,
    INPUT = 3'd1,
    PP    = 3'd2,
    OD    = 3'd3,
    TURN  = 3'd4
  } mode_e;

  localparam logic BUFDIR_HIZ      = 1'b0;
  localparam logic BUFOD_HIZ       = 1'b1;
  localparam int   SYNC_STAGES_DEF = 2;
  localparam int   TURN_CYCLES_DEF = 1;

  function automatic mode_e decode_mode(input logic oe, input logic od, input logic dir);
    if (!oe)     return HIZ;
    else if (dir) return INPUT;
    else if (od)  return OD;
    else          return PP;
  endfunction

  function automatic logic is_drive(input mode_e m);
    return (m == PP) || (m == OD);
  endfunction

endpackage

// File: rtl/iobuff_chan.sv
// iobuff_chan -- single-pin I/O buffer controller.
// Decodes the logical request into a mode, sequences break-before-make
// turnarounds between the two drive modes, registers the buffer controls
// and synchronizes the pin readback.
// Optional feature: IOBUFF_CONTENTION_DETECT_EN adds o_contention.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_oe/i_od/i_dir  : logical request (enable, open-drain, direction)
//   i_din            : value to drive
//   i_pin            : asynchronous pin level from the tristate primitive
//   o_dout           : synchronized pin level
//   o_bufdir, o_bufod: transceiver DIR and open-drain buffer input
//   o_tri_oe/o_tri_dout : tristate data pin enable / value
//   o_contention     : sticky drive-mismatch flag (feature build only)
module iobuff_chan
  import iobuff_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TURN_CYCLES = TURN_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_oe,
  input  logic i_od,
  input  logic i_dir,
  input  logic i_din,
  input  logic i_pin,
  output logic o_dout,
  output logic o_bufdir,
  output logic o_bufod,
  output logic o_tri_oe,
  output logic o_tri_dout
`ifdef IOBUFF_CONTENTION_DETECT_EN
  ,
  output logic o_contention
`endif
);

  localparam int CW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);

  mode_e           w_mode, w_next, r_state;
  logic [CW-1:0]   w_cnt_next, r_cnt;
  logic [SYNC_STAGES-1:0] r_sync;

  assign w_mode = decode_mode(i_oe, i_od, i_dir);

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    if (w_mode == HIZ) begin
      // Disabling always wins, even mid-turnaround.
      w_next     = HIZ;
      w_cnt_next = '0;
    end else if (r_state == TURN) begin
      // Turnaround runs to completion, then takes the latest request.
      if (r_cnt == TURN_LAST) begin
        w_next     = w_mode;
        w_cnt_next = '0;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end else if (w_mode != r_state) begin
      if (is_drive(w_mode) && is_drive(r_state)) begin
        w_next     = TURN;
        w_cnt_next = '0;
      end else begin
        w_next = w_mode;
      end
    end
  end

  // Outputs are registered from the next state so a request change reaches
  // the pin exactly one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HIZ;
      r_cnt      <= '0;
      o_bufdir   <= BUFDIR_HIZ;
      o_bufod    <= BUFOD_HIZ;
      o_tri_oe   <= 1'b0;
      o_tri_dout <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      o_bufdir   <= (w_next == PP) ? 1'b1 : BUFDIR_HIZ;
      o_bufod    <= (w_next == OD) ? i_din : BUFOD_HIZ;
      o_tri_oe   <= (w_next == PP);
      o_tri_dout <= (w_next == PP) && i_din;
    end
  end

  // Readback synchronizer runs in every state so open-drain levels are visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
  end

  assign o_dout = r_sync[SYNC_STAGES-1];

`ifdef IOBUFF_CONTENTION_DETECT_EN
  localparam int SW = $clog2(SYNC_STAGES + 2);
  localparam logic [SW-1:0] STAB_LIM = SW'(SYNC_STAGES + 1);

  logic          r_din_q;
  logic [SW-1:0] r_stab;
  logic          w_mismatch;

  // In OD a released pin (din=1) may legitimately be held low by another
  // driver, so only a failed pull-down counts.
  assign w_mismatch = is_drive(r_state) && (r_stab == STAB_LIM) &&
                      (o_dout != r_din_q) && ((r_state == PP) || !r_din_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din_q      <= 1'b0;
      r_stab       <= '0;
      o_contention <= 1'b0;
    end else begin
      r_din_q <= i_din;
      if (!is_drive(r_state) || (i_din != r_din_q)) r_stab <= '0;
      else if (r_stab != STAB_LIM)                   r_stab <= r_stab + 1'b1;
      if (!i_oe)           o_contention <= 1'b0;
      else if (w_mismatch) o_contention <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/iobuff.sv
// iobuff -- I/O buffer controller for WIDTH independent pins, each behind a
// 74LVC1T45 transceiver and a 74LVC1G07 open-drain buffer.
// Optional feature: IOBUFF_CONTENTION_DETECT_EN adds the contention port.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   oe, od, dir, din       : per-pin logical request and drive value
//   dout                   : synchronized pin level
//   bufdir, bufod          : buffer control pins
//   bufdat_tristate_oe/dout/din : FPGA tristate data pin
//   contention             : sticky drive-mismatch flags (feature build only)
// SYNC_STAGES must be >= 2 and TURN_CYCLES >= 1.
module iobuff
  import iobuff_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TURN_CYCLES = TURN_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] oe,
  input  logic [WIDTH-1:0] od,
  input  logic [WIDTH-1:0] dir,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] bufdir,
  output logic [WIDTH-1:0] bufod,
  output logic [WIDTH-1:0] bufdat_tristate_oe,
  output logic [WIDTH-1:0] bufdat_tristate_dout,
  input  logic [WIDTH-1:0] bufdat_tristate_din
`ifdef IOBUFF_CONTENTION_DETECT_EN
  ,
  output logic [WIDTH-1:0] contention
`endif
);

  // Reset asserts asynchronously (pins release at once) but releases
  // synchronously to clk.
  logic r_rst_meta, r_rst_sync;
  logic w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    iobuff_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .TURN_CYCLES(TURN_CYCLES)
    ) u_chan (
      .clk         (clk),
      .rst_n       (w_rst_n),
      .i_oe        (oe[g]),
      .i_od        (od[g]),
      .i_dir       (dir[g]),
      .i_din       (din[g]),
      .i_pin       (bufdat_tristate_din[g]),
      .o_dout      (dout[g]),
      .o_bufdir    (bufdir[g]),
      .o_bufod     (bufod[g]),
      .o_tri_oe    (bufdat_tristate_oe[g]),
      .o_tri_dout  (bufdat_tristate_dout[g])
`ifdef IOBUFF_CONTENTION_DETECT_EN
      ,
      .o_contention(contention[g])
`endif
    );
  end

endmodule

// File: tb/tb_iobuff.sv
// tb_iobuff -- directed bench for iobuff (WIDTH=1, SYNC_STAGES=2, TURN_CYCLES=1).
// Control outputs are checked packed as {bufdir, bufod, tri_oe, tri_dout}.
module tb_iobuff;

  logic clk = 1'b0;
  logic rst_n;
  logic [0:0] oe, od, dir, din, pin;
  logic [0:0] dout, bufdir, bufod, tri_oe, tri_dout;
`ifdef IOBUFF_CONTENTION_DETECT_EN
  logic [0:0] contention;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [3:0] CTL_HIZ = 4'b0100;

  iobuff #(.WIDTH(1), .SYNC_STAGES(2), .TURN_CYCLES(1)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .oe                  (oe),
    .od                  (od),
    .dir                 (dir),
    .din                 (din),
    .dout                (dout),
    .bufdir              (bufdir),
    .bufod               (bufod),
    .bufdat_tristate_oe  (tri_oe),
    .bufdat_tristate_dout(tri_dout),
    .bufdat_tristate_din (pin)
`ifdef IOBUFF_CONTENTION_DETECT_EN
    ,
    .contention          (contention)
`endif
  );

  always #5 clk = ~clk;

  wire [3:0] ctl = {bufdir, bufod, tri_oe, tri_dout};

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; oe = 0; od = 0; dir = 0; din = 0; pin = 0;
    tick(2);
    n_cmp++; if (ctl !== CTL_HIZ) begin n_bad++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_HIZ); end
    n_cmp++; if (dout !== 1'b0) begin n_bad++; $display("FAIL reset_dout: got %b want 0", dout); end
    rst_n = 1'b1;
    tick(3);
    n_cmp++; if (ctl !== CTL_HIZ) begin n_bad++; $display("FAIL post_reset_ctl: got %b want %b", ctl, CTL_HIZ); end
  endtask

  task automatic test_pushpull();
    oe = 1; od = 0; dir = 0; din = 0;
    #1;
    n_cmp++; if (ctl !== CTL_HIZ) begin n_bad++; $display("FAIL pp_latency: got %b want %b", ctl, CTL_HIZ); end
    tick();
    n_cmp++; if (ctl !== 4'b1110) begin n_bad++; $display("FAIL pp_drive0: got %b want 1110", ctl); end
    tick(19);
    n_cmp++; if (ctl !== 4'b1110) begin n_bad++; $display("FAIL pp_hold: got %b want 1110", ctl); end
    din = 1;
    tick();
    n_cmp++; if (ctl !== 4'b1111) begin n_bad++; $display("FAIL pp_drive1: got %b want 1111", ctl); end
  endtask

  task automatic test_turnaround();
    od = 1;
    tick();
    n_cmp++; if (ctl !== CTL_HIZ) begin n_bad++; $display("FAIL turn_pp_od: got %b want %b", ctl, CTL_HIZ); end
    tick();
    n_cmp++; if (ctl !== 4'b0100) begin n_bad++; $display("FAIL od_release: got %b want 0100", ctl); end
    din = 0;
    tick();
    n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL od_pull: got %b want 0000", ctl); end
    od = 0; din = 1;
    tick();
    n_cmp++; if (ctl !== CTL_HIZ) begin n_bad++; $display("FAIL turn_od_pp: got %b want %b", ctl, CTL_HIZ); end
    tick();
    n_cmp++; if (ctl !== 4'b1111) begin n_bad++; $display("FAIL od_to_pp: got %b want 1111", ctl); end
  endtask

  task automatic test_input();
    dir = 1; pin = 0;
    tick();
    n_cmp++; if (ctl !== CTL_HIZ) begin n_bad++; $display("FAIL input_ctl: got %b want %b", ctl, CTL_HIZ); end
    tick(3);
    pin = 1;
    tick();
    n_cmp++; if (dout !== 1'b0) begin n_bad++; $display("FAIL input_dout_1clk: got %b want 0", dout); end
    tick();
    n_cmp++; if (dout !== 1'b1) begin n_bad++; $display("FAIL input_dout_2clk: got %b want 1", dout); end
    pin = 0;
    tick(2);
    n_cmp++; if (dout !== 1'b0) begin n_bad++; $display("FAIL input_dout_fall: got %b want 0", dout); end
  endtask

  task automatic test_oe_off();
    dir = 0; od = 0; din = 1;
    tick();
    n_cmp++; if (ctl !== 4'b1111) begin n_bad++; $display("FAIL oe_pp_entry: got %b want 1111", ctl); end
    oe = 0;
    tick();
    n_cmp++; if (ctl !== CTL_HIZ) begin n_bad++; $display("FAIL oe_off: got %b want %b", ctl, CTL_HIZ); end
  endtask

  task automatic test_async_reset();
    oe = 1; od = 0; dir = 0; din = 1; pin = 1;
    tick(3);
    n_cmp++; if (ctl !== 4'b1111 || dout !== 1'b1) begin n_bad++; $display("FAIL arst_pre: got %b/%b want 1111/1", ctl, dout); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ctl !== CTL_HIZ) begin n_bad++; $display("FAIL arst_ctl: got %b want %b", ctl, CTL_HIZ); end
    n_cmp++; if (dout !== 1'b0) begin n_bad++; $display("FAIL arst_dout: got %b want 0", dout); end
    oe = 0; din = 0; pin = 0;
    tick();
    rst_n = 1'b1;
    tick(3);
  endtask

`ifdef IOBUFF_CONTENTION_DETECT_EN
  task automatic test_contention();
    do_reset();
    oe = 1; od = 0; dir = 0; din = 1; pin = 0;
    tick();
    n_cmp++; if (contention !== 1'b0) begin n_bad++; $display("FAIL cont_early: got %b want 0", contention); end
    tick(5);
    n_cmp++; if (contention !== 1'b1) begin n_bad++; $display("FAIL cont_set: got %b want 1", contention); end
    oe = 0;
    tick();
    n_cmp++; if (contention !== 1'b0) begin n_bad++; $display("FAIL cont_clear: got %b want 0", contention); end
  endtask
`endif

  initial begin
    test_reset();
    test_pushpull();
    test_turnaround();
    test_input();
    test_oe_off();
    test_async_reset();
`ifdef IOBUFF_CONTENTION_DETECT_EN
    test_contention();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
